// File: rtl/if_stage_pkg.sv
// Shared constants, state encoding and IF/ID entry type for the fetch stage.
package if_stage_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int INS_ADDR_WIDTH = 32;
  localparam int INS_DATA_WIDTH = 32;

  localparam logic [INS_DATA_WIDTH-1:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic [INS_ADDR_WIDTH-1:0] START_INST_ADDR = 32'h0000_0000;
  localparam logic [INS_ADDR_WIDTH-1:0] INST_STEP       = 32'd4;

  // FETCH: a request is (or may be) outstanding; HOLD: one word parked in the skid buffer
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // One IF/ID slot as seen by decode
  typedef struct packed {
    logic [INS_ADDR_WIDTH-1:0] pc;
    logic [INS_DATA_WIDTH-1:0] inst;
    logic                      valid;
  } if_id_t;

  // Sequential successor; wraps naturally at 32 bits
  function automatic logic [INS_ADDR_WIDTH-1:0] next_seq_pc(input logic [INS_ADDR_WIDTH-1:0] pc);
    return pc + INST_STEP;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: freezes on decode stall, otherwise loads a fetched
// word or a bubble (nop, valid low, pc kept). Also carries the delay-slot flag.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      load,
  input  logic [INS_ADDR_WIDTH-1:0] load_pc,
  input  logic [INS_DATA_WIDTH-1:0] load_inst,
  input  logic                      next_delayslotEn,
  output logic [INS_ADDR_WIDTH-1:0] pc_o,
  output logic [INS_DATA_WIDTH-1:0] inst_o,
  output logic                      valid_o,
  output logic                      delayslotEn
);

  if_id_t entry_reg;
  if_id_t entry_next;
  logic   ds_reg;

  // Select between hold, fresh word and bubble
  always_comb begin
    entry_next = entry_reg;
    if (!hold) begin
      if (load) begin
        entry_next = '{pc: load_pc, inst: load_inst, valid: ENABLE};
      end else begin
        entry_next = '{pc: entry_reg.pc, inst: ZERO_WORD, valid: DISABLE};
      end
    end
  end

  // Register the slot and the delay-slot flag; both freeze while decode stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg <= '0;
      ds_reg    <= DISABLE;
    end else begin
      entry_reg <= entry_next;
      if (!hold) begin
        ds_reg <= next_delayslotEn;
      end
    end
  end

  assign pc_o        = entry_reg.pc;
  assign inst_o      = entry_reg.inst;
  assign valid_o     = entry_reg.valid;
  assign delayslotEn = ds_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding-request
// handshake to instruction memory, parks one word when decode stalls, and
// applies decode's branch redirect after the delay slot has been fetched.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INS_ADDR_WIDTH-1:0] RESET_PC = START_INST_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_req,
  input  logic                      branchEN,
  input  logic [INS_ADDR_WIDTH-1:0] branchAddr,
  input  logic                      next_delayslotEn,
  output logic                      imem_req,
  output logic [INS_ADDR_WIDTH-1:0] imem_addr,
  input  logic                      imem_ready,
  input  logic [INS_DATA_WIDTH-1:0] imem_rdata,
  output logic [INS_ADDR_WIDTH-1:0] pc_o,
  output logic [INS_DATA_WIDTH-1:0] inst_o,
  output logic                      valid_o,
  output logic                      delayslotEn
);

  fetch_state_e              state_reg, state_next;
  logic [INS_ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [INS_DATA_WIDTH-1:0] hold_inst_reg, hold_inst_next;
  logic [INS_ADDR_WIDTH-1:0] hold_pc_reg, hold_pc_next;
  logic                      redir_pend_reg, redir_pend_next;
  logic [INS_ADDR_WIDTH-1:0] redir_addr_reg, redir_addr_next;

  logic                      accept;
  logic                      br;
  logic                      load_if_id;
  logic [INS_ADDR_WIDTH-1:0] load_pc;
  logic [INS_DATA_WIDTH-1:0] load_inst;

  // Decode takes a new slot whenever it is not stalled; a redirect only counts then
  assign accept = ~stall_req;
  assign br     = accept & branchEN;

  // Next-state, PC, skid and redirect logic
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    hold_inst_next  = hold_inst_reg;
    hold_pc_next    = hold_pc_reg;
    redir_pend_next = redir_pend_reg;
    redir_addr_next = redir_addr_reg;
    imem_req        = DISABLE;
    load_if_id      = DISABLE;
    load_pc         = pc_reg;
    load_inst       = imem_rdata;

    case (state_reg)
      FETCH: begin
        imem_req = ~rst;
        if (imem_ready) begin
          load_if_id = ENABLE;
          // Decode is stalled: park the word instead of dropping it
          if (!accept) begin
            hold_inst_next = imem_rdata;
            hold_pc_next   = pc_reg;
            state_next     = HOLD;
          end
          // A branch in the same cycle as the delay-slot word goes straight to its target
          if (br) begin
            pc_next = branchAddr;
          end else if (redir_pend_reg) begin
            pc_next = redir_addr_reg;
          end else begin
            pc_next = next_seq_pc(pc_reg);
          end
          redir_pend_next = DISABLE;
        end else if (br) begin
          // The fetch still in flight is the delay slot; remember where to go afterwards
          redir_pend_next = ENABLE;
          redir_addr_next = branchAddr;
        end
      end

      HOLD: begin
        load_pc   = hold_pc_reg;
        load_inst = hold_inst_reg;
        if (accept) begin
          load_if_id = ENABLE;
          state_next = FETCH;
        end
        // The parked word is the delay slot and pc already moved past it
        if (br) begin
          pc_next = branchAddr;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State, PC, skid buffer and pending-redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      hold_inst_reg  <= ZERO_WORD;
      hold_pc_reg    <= ZERO_WORD;
      redir_pend_reg <= DISABLE;
      redir_addr_reg <= ZERO_WORD;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      hold_inst_reg  <= hold_inst_next;
      hold_pc_reg    <= hold_pc_next;
      redir_pend_reg <= redir_pend_next;
      redir_addr_reg <= redir_addr_next;
    end
  end

  assign imem_addr = pc_reg;

  if_id_reg u_if_id_reg (
    .clk              (clk),
    .rst              (rst),
    .hold             (stall_req),
    .load             (load_if_id),
    .load_pc          (load_pc),
    .load_inst        (load_inst),
    .next_delayslotEn (next_delayslotEn),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .valid_o          (valid_o),
    .delayslotEn      (delayslotEn)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory responder with selectable latency, a program-order
// reference model of what decode must receive, directed literal cases, random run.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_req = 1'b0;
  logic        branchEN = 1'b0;
  logic [31:0] branchAddr = 32'h0;
  logic        next_delayslotEn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        delayslotEn;

  localparam logic [31:0] RST_PC = 32'h0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_req        (stall_req),
    .branchEN         (branchEN),
    .branchAddr       (branchAddr),
    .next_delayslotEn (next_delayslotEn),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .valid_o          (valid_o),
    .delayslotEn      (delayslotEn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory responder state
  int          lat_fixed = 0;    // <0 means random 0..3
  logic [31:0] data_xor  = 32'h0;
  bit          busy      = 0;
  int          wait_cnt  = 0;
  logic [31:0] req_addr  = 32'h0;

  // reference model: what decode holds, the parked word, and expected program order
  bit          m_valid = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  bit          m_ds = 0;
  bit          buf_n = 0;
  logic [31:0] buf_pc = 32'h0;
  logic [31:0] buf_inst = 32'h0;
  logic [31:0] exp_next = RST_PC;
  bit          tgt_pend = 0;
  logic [31:0] tgt = 32'h0;
  bit          in_ds = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ data_xor;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic deliver(input logic [31:0] pc, input logic [31:0] inst);
    m_pc    = pc;
    m_inst  = inst;
    m_valid = 1;
    $display("deliver pc=%08h inst=%08h", pc, inst);
    chk("order_pc", pc, exp_next);
    if (tgt_pend) begin
      exp_next = tgt;
      tgt_pend = 0;
      in_ds    = 1;
    end else begin
      exp_next = exp_next + 32'd4;
      in_ds    = 0;
    end
  endtask

  // One clock: drive inputs, answer memory, advance model, then compare after the edge
  task automatic step(input bit r, input bit st, input bit be, input logic [31:0] ba, input bit nds);
    bit got;
    logic [31:0] got_data;
    @(negedge clk);
    rst = r; stall_req = st; branchEN = be; branchAddr = ba; next_delayslotEn = nds;
    #1;
    got = 0;
    got_data = 32'h0;
    chk("imem_req", {31'h0, imem_req}, {31'h0, (!r && buf_n == 0)});
    imem_ready = 1'($urandom_range(0, 1));
    imem_rdata = $urandom();
    if (r) begin
      busy = 0;
    end else if (imem_req) begin
      if (!busy) begin
        busy     = 1;
        req_addr = imem_addr;
        wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      if (wait_cnt == 0) begin
        imem_ready = 1'b1;
        got_data   = mem_word(req_addr);
        imem_rdata = got_data;
        got        = 1;
        busy       = 0;
      end else begin
        imem_ready = 1'b0;
        wait_cnt--;
      end
    end else begin
      chk("req_withdrawn", {31'h0, busy}, 32'h0);
    end

    if (r) begin
      m_valid = 0; m_pc = 32'h0; m_inst = 32'h0; m_ds = 0;
      buf_n = 0; exp_next = RST_PC; tgt_pend = 0; in_ds = 0;
    end else if (st) begin
      if (got) begin
        buf_n    = 1;
        buf_pc   = req_addr;
        buf_inst = got_data;
      end
    end else begin
      m_ds = nds;
      if (be) begin
        tgt_pend = 1;
        tgt      = ba;
      end
      if (buf_n) begin
        buf_n = 0;
        deliver(buf_pc, buf_inst);
      end else if (got) begin
        deliver(req_addr, got_data);
      end else begin
        m_valid = 0;
        m_inst  = 32'h0;
      end
    end

    @(posedge clk);
    #1;
    chk("valid_o", {31'h0, valid_o}, {31'h0, m_valid});
    chk("inst_o", inst_o, m_inst);
    chk("pc_o", pc_o, m_pc);
    chk("delayslotEn", {31'h0, delayslotEn}, {31'h0, m_ds});
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, st, be, nds, can_br;
    logic [31:0] ba;
    int sel;

    // reset values
    lat_fixed = 0; data_xor = 32'h0;
    do_reset();
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ds", {31'h0, delayslotEn}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);

    // zero-wait memory: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 0);
      chk("zw_inst", inst_o, 32'(4 * i));
      chk("zw_valid", {31'h0, valid_o}, 32'h1);
    end

    // two extra wait cycles per fetch
    lat_fixed = 0; do_reset(); lat_fixed = 2;
    step(0, 0, 0, 32'h0, 0); chk("lat_b1_valid", {31'h0, valid_o}, 32'h0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0); chk("lat_w0_inst", inst_o, 32'h0); chk("lat_w0_valid", {31'h0, valid_o}, 32'h1);
    step(0, 0, 0, 32'h0, 0); chk("lat_addr_a", imem_addr, 32'h4); chk("lat_b2_valid", {31'h0, valid_o}, 32'h0);
    step(0, 0, 0, 32'h0, 0); chk("lat_addr_b", imem_addr, 32'h4); chk("lat_b3_inst", inst_o, 32'h0);
    step(0, 0, 0, 32'h0, 0); chk("lat_w4_inst", inst_o, 32'h4); chk("lat_w4_pc", pc_o, 32'h4);

    // stall for three cycles while the word at 0x8 arrives
    lat_fixed = 0; do_reset();
    run(2);
    step(0, 1, 0, 32'h0, 1); chk("st_req", {31'h0, imem_req}, 32'h0); chk("st_inst_a", inst_o, 32'h4);
    step(0, 1, 1, 32'h40, 1);
    step(0, 1, 0, 32'h0, 1); chk("st_inst_b", inst_o, 32'h4); chk("st_ds_frozen", {31'h0, delayslotEn}, 32'h0);
    step(0, 0, 0, 32'h0, 1); chk("st_rel_inst", inst_o, 32'h8); chk("st_rel_ds", {31'h0, delayslotEn}, 32'h1);
    chk("st_rel_addr", imem_addr, 32'hC); chk("st_rel_req", {31'h0, imem_req}, 32'h1);
    step(0, 0, 0, 32'h0, 0); chk("st_next_inst", inst_o, 32'hC);

    // branch at 0x10 coincident with delay-slot ready
    lat_fixed = 0; do_reset();
    run(5); chk("br_at", pc_o, 32'h10);
    step(0, 0, 1, 32'h100, 1); chk("br_ds", pc_o, 32'h14);
    step(0, 0, 0, 32'h0, 0); chk("br_tgt", inst_o, 32'h100);
    step(0, 0, 0, 32'h0, 0); chk("br_tgt4", inst_o, 32'h104);

    // branch sampled while the delay slot is parked
    lat_fixed = 0; do_reset();
    run(5);
    step(0, 1, 0, 32'h0, 0); chk("hb_req", {31'h0, imem_req}, 32'h0);
    step(0, 0, 1, 32'h200, 0); chk("hb_ds", inst_o, 32'h14); chk("hb_addr", imem_addr, 32'h200);
    step(0, 0, 0, 32'h0, 0); chk("hb_tgt", inst_o, 32'h200);

    // branch while the delay-slot fetch is still waiting
    lat_fixed = 0; do_reset();
    run(5);
    lat_fixed = 2;
    step(0, 0, 1, 32'h300, 0); chk("pb_bubble", {31'h0, valid_o}, 32'h0); chk("pb_addr_a", imem_addr, 32'h14);
    step(0, 0, 0, 32'h0, 0); chk("pb_addr_b", imem_addr, 32'h14);
    step(0, 0, 0, 32'h0, 0); chk("pb_ds", inst_o, 32'h14); chk("pb_addr_t", imem_addr, 32'h300);
    lat_fixed = 0;
    step(0, 0, 0, 32'h0, 0); chk("pb_tgt", inst_o, 32'h300);

    // address wrap at the top of memory
    lat_fixed = 0; do_reset();
    run(5);
    step(0, 0, 1, 32'hFFFF_FFF8, 0);
    step(0, 0, 0, 32'h0, 0); chk("wrap_a", pc_o, 32'hFFFF_FFF8);
    step(0, 0, 0, 32'h0, 0); chk("wrap_b", pc_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 0); chk("wrap_c", pc_o, 32'h0); chk("wrap_valid", {31'h0, valid_o}, 32'h1);

    // reset while the fetch of 0x20 is outstanding
    lat_fixed = 0; do_reset();
    run(8);
    lat_fixed = 3;
    step(0, 0, 0, 32'h0, 0); chk("rm_addr", imem_addr, 32'h20); chk("rm_req", {31'h0, imem_req}, 32'h1);
    step(1, 0, 0, 32'h0, 0); chk("rm_req0", {31'h0, imem_req}, 32'h0); chk("rm_valid", {31'h0, valid_o}, 32'h0);
    chk("rm_pc_reset", imem_addr, RST_PC);
    lat_fixed = 0;
    step(0, 0, 0, 32'h0, 0); chk("rm_first_pc", pc_o, RST_PC); chk("rm_first_valid", {31'h0, valid_o}, 32'h1);

    // randomized traffic against the model
    lat_fixed = -1; data_xor = 32'h5A3C_0000;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      r   = ($urandom_range(0, 399) == 0);
      st  = ($urandom_range(0, 9) < 3);
      nds = 1'($urandom_range(0, 1));
      can_br = m_valid && !tgt_pend && !in_ds;
      be  = st ? ($urandom_range(0, 3) == 0) : (can_br && $urandom_range(0, 4) == 0);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      ba = 32'hFFFF_FFF4;
      else if (sel == 1) ba = ($urandom() & 32'h0000_FFFC) | 32'h1;
      else               ba = $urandom() & 32'h0003_FFFC;
      step(r, st, be, ba, nds);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Owns the PC, drives a single-outstanding-request instruction-memory handshake, buffers one fetched word when decode stalls, and holds the IF/ID pipeline register (pc, inst, valid, delay-slot flag). Consumes decode's branch redirect (`branchEN`/`branchAddr`), load-use stall, and delay-slot outputs.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high (`ENABLE`).
- `stall_req` in 1: decode stall. When high, the IF/ID register holds; branch inputs are ignored.
- `branchEN` in 1: decode redirect request, valid only when `stall_req`=0.
- `branchAddr` in 32: redirect target.
- `next_delayslotEn` in 1: decode's delay-slot flag, registered into `delayslotEn`.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equals the PC register.
- `imem_ready` in 1: read data valid this cycle. Sampled only when `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `pc_o` out 32: PC of the instruction in IF/ID.
- `inst_o` out 32: instruction in IF/ID. 32'h0 (nop) when empty.
- `valid_o` out 1: IF/ID holds a real instruction.
- `delayslotEn` out 1: to decode `delayslotEn`.

## Operation
- PC register `pc_r`. FSM states: FETCH and HOLD. Additional registers: skid buffer (`hold_inst`, `hold_pc`), `redir_pend`, `redir_addr`.
- Accept event: `accept = ~stall_req`.
- Branch sample: `br = accept & branchEN`. This is the cycle the branch leaves decode. The next instruction decode receives is the delay slot.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready` with `accept`: load IF/ID with {pc_r, imem_rdata, valid=1}.
  - On `imem_ready` without `accept`: load the skid buffer and go to HOLD.
  - In either ready case, update `pc_r` to, in priority order: `branchAddr` if `br`; else `redir_addr` if `redir_pend`; else `pc_r+4`. Clear `redir_pend` on that update.
  - `br` without `imem_ready`: set `redir_pend` and `redir_addr`. The outstanding fetch is the delay slot and completes normally.
- HOLD:
  - `imem_req`=0.
  - On `accept`: load IF/ID from the skid buffer and go to FETCH.
  - On `br` in HOLD: `pc_r <= branchAddr` directly (the PC increment has already happened).
- IF/ID with `accept` and no new word available (FETCH without ready): load bubble {pc_o unchanged, inst 0, valid 0}.
- `delayslotEn <= next_delayslotEn` when `accept`; holds otherwise.
- Address arithmetic: 32-bit wrap. 32'hFFFF_FFFC+4 = 0. Low two bits of `branchAddr` pass through unchecked.

## Timing
- Reset values:
  - `pc_r`/`imem_addr` = `RESET_PC`.
  - `imem_req`, `valid_o`, `delayslotEn`, `redir_pend` = 0.
  - `inst_o`, `pc_o` = 0.
  - State = FETCH.
  - `imem_req` is forced 0 while `rst`=1.
- Reset mid-fetch abandons the request. The instruction memory is reset by the same `rst`. `imem_ready` is ignored during reset.
- `imem_addr` is stable while `imem_req`=1 until `imem_ready`.
- Zero-wait memory (ready in the request cycle) gives 1 instruction/cycle.
- Latency: the word returned in cycle N appears on `inst_o` in cycle N+1 if accepted.
- Branch sampled in cycle N: the delay slot reaches decode at the next accept. The target is requested no later than the cycle after the delay-slot fetch completes.
- Simultaneous `br` and `imem_ready`: the PC goes straight to `branchAddr` and no pending redirect is set.
- `stall_req` held for K cycles: IF/ID and `delayslotEn` are frozen K cycles. At most one word is buffered, and no request is issued while in HOLD.

## Structure
- `defines.v`: `ENABLE`/`DISABLE`, `ZeroWord`, `InsAddrWidth`, `InsDataBus`, `StartInstAddr` (drives `RESET_PC`), FETCH/HOLD state encodings.
- One sub-module: `if_id_reg` (IF/ID register with hold/bubble/load controls and `delayslotEn`). FSM, PC, and skid buffer stay in `if_stage`.

## Test plan
- Reset then zero-wait memory returning addr-as-data: `inst_o` = 0,4,8,C on consecutive cycles; `valid_o`=1 from cycle 2.
- Memory with 2-cycle ready latency: `imem_addr` holds 0x4 across the wait; `inst_o` shows one bubble (inst 0, valid 0) per extra wait cycle.
- `stall_req` high 3 cycles while fetch of 0x8 completes: state HOLD, `imem_req`=0; on release `inst_o`=word@0x8, then fetch 0xC.
- `branchEN`=1, `branchAddr`=0x100 with branch at 0x10, `stall_req`=0: decode receives 0x14 (delay slot) then 0x100.
- Branch sampled in HOLD and branch sampled coincident with `imem_ready`: both deliver the delay slot, then the target, with no extra 0x18 fetch.
- `rst` asserted mid-fetch at 0x20: next cycle `imem_req`=0, `valid_o`=0; after release the first request is `RESET_PC`.
